// File: rtl/ascon_block_packer.sv
// Packs a 32-bit word stream into 64-bit big-endian Ascon-128 rate blocks,
// applying 0x80-then-zeros padding and flagging the final block of each message.
module ascon_block_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h80
) (
    input  logic        clock_i,
    input  logic        resetb_i,
    input  logic [31:0] data_i,
    input  logic        data_valid_i,
    input  logic        data_last_i,
    input  logic [2:0]  data_bytes_i,
    output logic        data_ready_o,
    output logic [63:0] block_o,
    output logic        block_valid_o,
    output logic        block_last_o,
    input  logic        block_ready_i
);

    typedef enum logic [1:0] {
        S_HI  = 2'd0,
        S_LO  = 2'd1,
        S_OUT = 2'd2,
        S_PAD = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [63:0] buf_reg, buf_next;
    logic        last_flag_reg, last_flag_next;
    logic        pad_pending_reg, pad_pending_next;

    logic [2:0]  n_bytes;
    logic        last_full;
    logic [31:0] masked_word;
    logic [31:0] padded_word;
    logic        word_fire;
    logic        block_fire;

    assign n_bytes   = (data_bytes_i > 3'd4) ? 3'd4 : data_bytes_i;
    assign last_full = (n_bytes == 3'd4);

    // Per-lane masking of bytes past the message end, and pad insertion at lane n.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign masked_word[31-8*gi -: 8] =
                (!data_last_i || (3'(gi) < n_bytes)) ? data_i[31-8*gi -: 8] : 8'h00;
            assign padded_word[31-8*gi -: 8] =
                (3'(gi) == n_bytes) ? PAD_BYTE : masked_word[31-8*gi -: 8];
        end
    endgenerate

    assign data_ready_o  = !resetb_i && ((state_reg == S_HI) || (state_reg == S_LO));
    assign block_valid_o = (state_reg == S_OUT) || (state_reg == S_PAD);
    assign block_last_o  = (state_reg == S_PAD) || ((state_reg == S_OUT) && last_flag_reg);
    assign block_o       = (state_reg == S_PAD) ? {PAD_BYTE, 56'h0} : buf_reg;

    assign word_fire  = data_valid_i && data_ready_o;
    assign block_fire = block_valid_o && block_ready_i;

    always_comb begin
        state_next       = state_reg;
        buf_next         = buf_reg;
        last_flag_next   = last_flag_reg;
        pad_pending_next = pad_pending_reg;
        case (state_reg)
            S_HI: begin
                if (word_fire) begin
                    if (!data_last_i) begin
                        buf_next[63:32] = data_i;
                        state_next      = S_LO;
                    end else begin
                        // A full last word pushes the pad into the low half.
                        buf_next       = {padded_word, last_full ? {PAD_BYTE, 24'h0} : 32'h0};
                        last_flag_next = 1'b1;
                        state_next     = S_OUT;
                    end
                end
            end
            S_LO: begin
                if (word_fire) begin
                    state_next = S_OUT;
                    if (!data_last_i) begin
                        buf_next[31:0] = data_i;
                        last_flag_next = 1'b0;
                    end else if (!last_full) begin
                        buf_next[31:0] = padded_word;
                        last_flag_next = 1'b1;
                    end else begin
                        // Message fills the block exactly: pad goes out as its own block.
                        buf_next[31:0]   = masked_word;
                        last_flag_next   = 1'b0;
                        pad_pending_next = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (block_fire) begin
                    state_next = pad_pending_reg ? S_PAD : S_HI;
                end
            end
            S_PAD: begin
                if (block_fire) begin
                    pad_pending_next = 1'b0;
                    state_next       = S_HI;
                end
            end
            default: state_next = S_HI;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (resetb_i) begin
            state_reg       <= S_HI;
            buf_reg         <= 64'h0;
            last_flag_reg   <= 1'b0;
            pad_pending_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            buf_reg         <= buf_next;
            last_flag_reg   <= last_flag_next;
            pad_pending_reg <= pad_pending_next;
        end
    end

endmodule

// File: tb/tb_ascon_block_packer.sv
// Randomized and directed bench for ascon_block_packer; expected blocks come from
// padding each byte message and cutting it into 8-byte chunks.
module tb_ascon_block_packer;

    logic        clk;
    logic        srst;
    logic [31:0] data_i;
    logic        data_valid;
    logic        data_last;
    logic [2:0]  data_bytes;
    logic        data_ready;
    logic [63:0] block;
    logic        block_valid;
    logic        block_last;
    logic        block_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0]  msg_q[$];
    logic [31:0] wd_q[$];
    logic        wl_q[$];
    logic [2:0]  wn_q[$];
    logic [64:0] exp_q[$];

    ascon_block_packer #(.PAD_BYTE(8'h80)) dut (
        .clock_i      (clk),
        .resetb_i     (srst),
        .data_i       (data_i),
        .data_valid_i (data_valid),
        .data_last_i  (data_last),
        .data_bytes_i (data_bytes),
        .data_ready_o (data_ready),
        .block_o      (block),
        .block_valid_o(block_valid),
        .block_last_o (block_last),
        .block_ready_i(block_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // mode 0: random word split, 1: final full word carries n=4, 2: extra empty last word
    task automatic build(input int mode);
        int          len;
        int          nblk;
        int          nw;
        bit          extra;
        logic [7:0]  padded[$];
        logic [63:0] val;
        logic [31:0] w;
        int          n;
        len = msg_q.size();
        padded = msg_q;
        padded.push_back(8'h80);
        while (padded.size() % 8 != 0) padded.push_back(8'h00);
        nblk = len / 8 + 1;
        exp_q.delete();
        for (int b = 0; b < nblk; b++) begin
            val = 64'h0;
            for (int k = 0; k < 8; k++) val = {val[55:0], padded[8*b+k]};
            exp_q.push_back({(b == nblk - 1), val});
        end
        extra = (len == 0) || (mode == 2) || (mode == 0 && $urandom_range(0, 1) == 1);
        nw = ((len % 4) != 0 || extra) ? len / 4 + 1 : len / 4;
        wd_q.delete(); wl_q.delete(); wn_q.delete();
        for (int i = 0; i < nw; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++)
                w = {w[23:0], (4*i + k < len) ? msg_q[4*i+k] : 8'($urandom)};
            n = (i == nw - 1) ? len - 4*i : 4;
            wd_q.push_back(w);
            wl_q.push_back(i == nw - 1);
            wn_q.push_back((n == 4) ? 3'($urandom_range(4, 7)) : 3'(n));
        end
    endtask

    task automatic run_msg();
        int          widx = 0;
        int          cyc = 0;
        bit          dv;
        bit          br;
        bit          hold_v = 0;
        logic [63:0] hold_b = 64'h0;
        logic [64:0] e;
        while ((widx < wd_q.size() || exp_q.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            dv = (widx < wd_q.size()) && ($urandom_range(0, 3) != 0);
            if (dv) begin
                data_i     = wd_q[widx];
                data_last  = wl_q[widx];
                data_bytes = wn_q[widx];
            end else begin
                data_i     = $urandom;
                data_last  = 1'($urandom);
                data_bytes = 3'($urandom);
            end
            data_valid  = dv;
            br          = ($urandom_range(0, 2) != 0);
            block_ready = br;
            #1;
            if (hold_v) begin
                check("hold_valid", 64'(block_valid), 64'd1);
                check("hold_block", block, hold_b);
            end
            if (block_valid && br) begin
                if (exp_q.size() == 0) begin
                    check("extra_block", 64'(block_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("block %h last %b (expected %h last %b)", block, block_last, e[63:0], e[64]);
                    check("block", block, e[63:0]);
                    check("block_last", 64'(block_last), 64'(e[64]));
                end
            end
            hold_v = block_valid && !br;
            hold_b = block;
            if (dv && data_ready) widx++;
        end
        @(negedge clk);
        data_valid  = 1'b0;
        block_ready = 1'b0;
        check("timeout", 64'(wd_q.size() - widx + exp_q.size()), 64'd0);
    endtask

    initial begin
        srst = 1'b1; data_i = 32'h0; data_valid = 1'b0; data_last = 1'b0;
        data_bytes = 3'd0; block_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_valid", 64'(block_valid), 64'd0);
        check("rst_last", 64'(block_last), 64'd0);
        check("rst_block", block, 64'h0);
        check("rst_ready", 64'(data_ready), 64'd0);
        srst = 1'b0; #1;
        check("post_rst_ready", 64'(data_ready), 64'd1);

        // 8-byte message: full block, then a separate pad block
        msg_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        build(1); run_msg();
        // 3-byte message with a junk fourth byte
        msg_q = '{8'hAA, 8'hBB, 8'hCC};
        build(0); wd_q[0] = 32'hAABBCCDD; wn_q[0] = 3'd3; run_msg();
        // 6-byte message
        msg_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        build(0); wd_q[1] = 32'h5566FFFF; wn_q[1] = 3'd2; run_msg();
        // empty message
        msg_q.delete();
        build(0); wd_q[0] = 32'hFFFFFFFF; wn_q[0] = 3'd0; run_msg();

        // backpressure: block held for 5 cycles while the next word waits upstream
        @(negedge clk);
        data_valid = 1'b1; data_i = 32'hAABBCCDD; data_last = 1'b1; data_bytes = 3'd3;
        @(posedge clk);
        @(negedge clk);
        data_i = 32'h11223344; data_last = 1'b0; data_bytes = 3'd0; #1;
        check("bp_valid", 64'(block_valid), 64'd1);
        check("bp_block", block, 64'hAABBCC8000000000);
        check("bp_last", 64'(block_last), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk); #1;
            $display("stall cycle %0d block %h valid %b ready %b", i, block, block_valid, data_ready);
            check("bp_hold_valid", 64'(block_valid), 64'd1);
            check("bp_hold_block", block, 64'hAABBCC8000000000);
            check("bp_data_ready", 64'(data_ready), 64'd0);
        end
        block_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        block_ready = 1'b0; #1;
        check("bp_after_valid", 64'(block_valid), 64'd0);
        check("bp_after_ready", 64'(data_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        data_i = 32'hDEADBEEF; data_last = 1'b1; data_bytes = 3'd0;
        @(posedge clk);
        @(negedge clk);
        data_valid = 1'b0; #1;
        check("bp_next_valid", 64'(block_valid), 64'd1);
        check("bp_next_block", block, 64'h1122334480000000);
        check("bp_next_last", 64'(block_last), 64'd1);
        block_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        block_ready = 1'b0;

        // reset mid-block discards the partial buffer
        data_valid = 1'b1; data_i = 32'h01020304; data_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        data_valid = 1'b0; srst = 1'b1; #1;
        check("mid_rst_ready", 64'(data_ready), 64'd0);
        check("mid_rst_valid", 64'(block_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        srst = 1'b0; #1;
        check("mid_post_valid", 64'(block_valid), 64'd0);
        check("mid_post_block", block, 64'h0);
        check("mid_post_ready", 64'(data_ready), 64'd1);
        msg_q = '{8'h0A, 8'h0B, 8'h0C};
        build(0); wd_q[0] = 32'h0A0B0C00; wn_q[0] = 3'd3; run_msg();

        // randomized messages
        for (int m = 0; m < 40; m++) begin
            int len;
            len = $urandom_range(0, 30);
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
            build(0);
            run_msg();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
